stall_controller: RTL
=====================

Name: stall_controller

Overview:
- Consumes the IDStall/EXStall hazard flags from the stall detector, plus the branch/jump resolution from ID.
- Drives the pipeline-register write enables and bubble/flush controls of the 5-stage pipelined MIPS CPU.
- Tracks consecutive-stall runs for a deadlock watchdog and keeps saturating performance counters for stall and flush cycles.
- Sits between the hazard detection logic and the PC / IF/ID / ID/EX / EX/MEM registers.

Parameters:
- CNT_W, 16: width of the performance counters (saturating).
- MAX_STALL, 8: consecutive stall cycles that trip the watchdog (at least 2).
- RUN_W, 4: width of the consecutive-stall counter; requires 2^RUN_W > MAX_STALL.

Ports:
- clk  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- IDStall  input  1  ID-stage hazard (branch operand not yet available)
- EXStall  input  1  EX-stage load-use hazard
- BranchTaken  input  1  beq/bne resolved taken in ID
- Jump  input  1  j decoded in ID
- PCWrite  output  1  PC load enable
- IFIDWrite  output  1  IF/ID load enable
- IFIDFlush  output  1  IF/ID cleared to nop next edge
- IDEXWrite  output  1  ID/EX load enable
- IDEXBubble  output  1  ID/EX loads nop controls
- EXMEMBubble  output  1  EX/MEM loads nop controls
- Hung  output  1  sticky watchdog flag
- StallCount  output  CNT_W  cycles with any stall asserted
- FlushCount  output  CNT_W  cycles with IFIDFlush asserted

Behaviour:
- States are RUN, ID_HOLD, EX_HOLD and HUNG (2-bit encoding), with asynchronous reset to RUN.
- Reset values:
  - State is RUN, the run counter is 0, and Hung is 0.
  - Both counters are 0.
  - Control outputs take the RUN decode for the current inputs.
- Control outputs are a combinational decode of the current inputs and state, with zero-cycle latency, so a stall must freeze the pipeline in the same cycle it is flagged.
- Priority is HUNG > EXStall > IDStall > BranchTaken/Jump > none.
- HUNG: PCWrite=IFIDWrite=IDEXWrite=0, all bubbles/flush=0, and no counter updates.
- EXStall=1:
  - PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1.
  - IDStall is ignored that cycle.
  - BranchTaken/Jump are ignored (the branch is held in ID and re-evaluated later).
- IDStall=1, EXStall=0: PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEXBubble=1, and BranchTaken/Jump are ignored.
- No stall, with BranchTaken or Jump: all writes=1 and IFIDFlush=1.
- Otherwise, all writes=1 and every bubble/flush output is 0.
- Next-state rules (from any state other than HUNG):
  - EXStall goes to EX_HOLD.
  - Else IDStall goes to ID_HOLD.
  - Else the next state is RUN.
- Run counter:
  - It increments on every cycle in which any stall is asserted.
  - It clears to 0 on a cycle with no stall.
  - A switch between EX_HOLD and ID_HOLD does not clear it.
  - When a stall cycle occurs with the run counter already at MAX_STALL-1, the next state is HUNG and Hung=1 from the following edge.
  - The FSM leaves HUNG only on reset.
- StallCount increments on any non-HUNG cycle with a stall and saturates at all-ones.
- FlushCount increments on any cycle with IFIDFlush=1 and saturates.
- Reset asserted mid-stall takes effect immediately (asynchronous): state, counters and Hung clear, and the outputs revert to the decode of the current inputs in RUN.
- X on the inputs is not handled.

Decomposition:
- The shared package/header holds the state encodings (RUN=0, ID_HOLD=1, EX_HOLD=2, HUNG=3) and the control-output bit positions.
- One sub-module, sat_counter (parameter width; inputs inc, clk, reset; output count), is instantiated twice for StallCount and FlushCount.

Test Plan:
- Reset with all inputs 0, then release:
  - PCWrite=IFIDWrite=IDEXWrite=1 and bubbles/flush=0.
  - Hung=0, StallCount=0, FlushCount=0.
- IDStall=1 for 1 cycle:
  - That cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1, EXMEMBubble=0.
  - After the edge: StallCount=1 and state RUN on the next idle cycle.
- EXStall=1 and IDStall=1 and BranchTaken=1 together:
  - IDEXWrite=0, EXMEMBubble=1, IDEXBubble=0, IFIDFlush=0.
  - StallCount=1, FlushCount=0.
- BranchTaken=1 for 1 cycle, then Jump=1 for 1 cycle, with no stalls: IFIDFlush=1 in both cycles, FlushCount=2, all writes=1.
- IDStall=1 held with MAX_STALL=8:
  - Hung=0 through the 8th edge and Hung=1 after it.
  - Then with IDStall=0: all writes remain 0, StallCount frozen at 8.
  - Assert reset: Hung=0 immediately without waiting for clk.
- StallCount with CNT_W=4:
  - Alternate stall/no-stall 20 times: StallCount saturates at 15.
  - Mid-count asynchronous reset clears both counters immediately.

Source files
------------

// File: rtl/stall_controller_pkg.sv
// Shared encodings for the pipeline stall controller: FSM states, control-word
// bit positions and the priority decode used to drive the pipeline registers.
package stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ID_HOLD = 2'd1,
    EX_HOLD = 2'd2,
    HUNG    = 2'd3
  } state_e;

  localparam int unsigned CTRL_W         = 6;
  localparam int unsigned CTRL_PCWRITE   = 5;
  localparam int unsigned CTRL_IFIDWRITE = 4;
  localparam int unsigned CTRL_IFIDFLUSH = 3;
  localparam int unsigned CTRL_IDEXWRITE = 2;
  localparam int unsigned CTRL_IDEXBUB   = 1;
  localparam int unsigned CTRL_EXMEMBUB  = 0;

  // Priority: HUNG > EXStall > IDStall > BranchTaken/Jump > none.
  function automatic logic [CTRL_W-1:0] ctrl_decode(
    input state_e st,
    input logic   ex_stall,
    input logic   id_stall,
    input logic   redirect
  );
    logic [CTRL_W-1:0] c;
    c = '0;
    if (st == HUNG) begin
      c = '0;
    end else if (ex_stall) begin
      c[CTRL_EXMEMBUB] = 1'b1;
    end else if (id_stall) begin
      c[CTRL_IDEXWRITE] = 1'b1;
      c[CTRL_IDEXBUB]   = 1'b1;
    end else begin
      c[CTRL_PCWRITE]   = 1'b1;
      c[CTRL_IFIDWRITE] = 1'b1;
      c[CTRL_IDEXWRITE] = 1'b1;
      c[CTRL_IFIDFLUSH] = redirect;
    end
    return c;
  endfunction

endpackage

// File: rtl/stall_controller_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: zero-latency control decode, consecutive-stall
// watchdog FSM and saturating stall/flush performance counters.
module stall_controller
  import stall_controller_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned RUN_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDStall,
  input  logic             EXStall,
  input  logic             BranchTaken,
  input  logic             Jump,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXBubble,
  output logic             EXMEMBubble,
  output logic             Hung,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              hung_q, hung_d;
  logic [CTRL_W-1:0] ctrl;
  logic              any_stall;
  logic              stall_inc;

  assign any_stall = IDStall | EXStall;
  assign stall_inc = any_stall && (state_q != HUNG);

  always_comb begin
    ctrl = ctrl_decode(state_q, EXStall, IDStall, BranchTaken | Jump);
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hung_d  = hung_q;
    if (state_q != HUNG) begin
      if (any_stall) begin
        // A hold-type switch (EX<->ID) keeps the run going; only idle cycles clear it.
        run_d   = run_q + 1'b1;
        state_d = EXStall ? EX_HOLD : ID_HOLD;
        if (run_q == RUN_W'(MAX_STALL - 1)) begin
          state_d = HUNG;
          hung_d  = 1'b1;
        end
      end else begin
        run_d   = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      run_q   <= '0;
      hung_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hung_q  <= hung_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl[CTRL_IFIDFLUSH]),
    .count (FlushCount)
  );

  assign PCWrite     = ctrl[CTRL_PCWRITE];
  assign IFIDWrite   = ctrl[CTRL_IFIDWRITE];
  assign IFIDFlush   = ctrl[CTRL_IFIDFLUSH];
  assign IDEXWrite   = ctrl[CTRL_IDEXWRITE];
  assign IDEXBubble  = ctrl[CTRL_IDEXBUB];
  assign EXMEMBubble = ctrl[CTRL_EXMEMBUB];
  assign Hung        = hung_q;

endmodule
